// File: rtl/sprite_pixel_renderer.sv
// Sprite pixel renderer: turns a registered detector word plus the live scan position into
// a lit/unlit pixel with entity ID, through a 2-stage pipeline behind a counter-alignment register.
module sprite_pixel_renderer #(
  parameter int UPSCALE_FACTOR = 5,
  parameter int TILE_SIZE      = 8,
  parameter int ACTIVE_H       = 640
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] entity_in,
  input  logic [9:0] counter_H,
  input  logic [9:0] counter_V,
  input  logic       pixel_en,
  output logic       pixel_on,
  output logic [3:0] pixel_id,
  output logic       pixel_valid
);

  localparam int SW = (UPSCALE_FACTOR > 1) ? $clog2(UPSCALE_FACTOR) : 1;
  // The sprite ROM is 8x8, so the in-tile column is always 3 bits wide.
  localparam int CW = 3;
  localparam logic [3:0] ID_EMPTY = 4'hF;

  typedef enum logic {SYNC_WAIT = 1'b0, TRACK = 1'b1} state_t;

  state_t          state;
  logic [9:0]      h_d1;
  logic            en_d1;
  logic [SW-1:0]   sub;
  logic [CW-1:0]   col;

  logic [2:0]      row_s1;
  logic [3:0]      id_s1;
  logic [1:0]      orient_s1;
  logic [CW-1:0]   col_s1;
  logic            transparent_s1;
  logic            en_s1;

  logic            resync;
  logic            track_now;
  logic [CW-1:0]   col_now;
  logic            transparent_now;
  logic [2:0]      rom_r;
  logic [2:0]      rom_c;
  logic [7:0]      rom_bits;
  logic            rom_bit;

  // Vertical position is reserved for a future row cross-check.
  logic unused_counter_v;
  assign unused_counter_v = ^counter_V;

  function automatic logic [7:0] rom_row(input logic [3:0] id, input logic [2:0] r);
    case (id)
      4'h0:    rom_row = 8'h01 << r;
      4'h1:    rom_row = 8'hFF;
      4'hF:    rom_row = 8'h00;
      default: rom_row = {id, id} ^ {5'b00000, r};
    endcase
  endfunction

  always_comb begin
    resync          = (h_d1 == 10'd0);
    track_now       = resync || (state == TRACK);
    col_now         = resync ? '0 : col;
    transparent_now = !track_now || (entity_in[5:2] == ID_EMPTY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_d1  <= 10'h3FF;
      en_d1 <= 1'b0;
    end else begin
      h_d1  <= counter_H;
      en_d1 <= pixel_en;
    end
  end

  // Line-start resync wins over a sub-pixel wrap in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SYNC_WAIT;
      sub   <= '0;
      col   <= '0;
    end else if (resync) begin
      state <= TRACK;
      sub   <= SW'(1);
      col   <= '0;
    end else if (state == TRACK) begin
      if (sub == SW'(UPSCALE_FACTOR - 1)) begin
        sub <= '0;
        col <= (col == CW'(TILE_SIZE - 1)) ? '0 : col + CW'(1);
      end else begin
        sub <= sub + SW'(1);
      end
      if (h_d1 >= 10'(ACTIVE_H)) state <= SYNC_WAIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1         <= 3'h7;
      id_s1          <= ID_EMPTY;
      orient_s1      <= 2'h3;
      col_s1         <= '0;
      transparent_s1 <= 1'b1;
      en_s1          <= 1'b0;
    end else begin
      row_s1         <= entity_in[8:6];
      id_s1          <= entity_in[5:2];
      orient_s1      <= entity_in[1:0];
      col_s1         <= col_now;
      transparent_s1 <= transparent_now;
      en_s1          <= en_d1;
    end
  end

  // Orientation flips are bitwise inversions of the 3-bit row/column (7-x).
  always_comb begin
    rom_r    = orient_s1[1] ? ~row_s1 : row_s1;
    rom_c    = orient_s1[0] ? ~col_s1 : col_s1;
    rom_bits = rom_row(id_s1, rom_r);
    rom_bit  = rom_bits[rom_c];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_on    <= 1'b0;
      pixel_id    <= ID_EMPTY;
      pixel_valid <= 1'b0;
    end else begin
      pixel_on    <= !transparent_s1 && rom_bit && en_s1;
      pixel_id    <= (!transparent_s1 && rom_bit && en_s1) ? id_s1 : ID_EMPTY;
      pixel_valid <= en_s1;
    end
  end

endmodule

// File: doc/sprite_pixel_renderer.md
SPRITE_PIXEL_RENDERER -- requirements
Module: sprite_pixel_renderer

Interface
REQ-001 SHALL have parameter UPSCALE_FACTOR, default 5, screen pixels per sprite pixel.
REQ-002 SHALL have parameter TILE_SIZE, default 8, sprite pixels per tile edge.
REQ-003 SHALL have parameter ACTIVE_H, default 640, active-video width in screen pixels.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port entity_in, input, 9, registered detector word: [8:6] sprite row, [5:2] entity ID, [1:0] orientation; one cycle behind the counters.
REQ-007 SHALL have port counter_H, input, 10, live horizontal scan position.
REQ-008 SHALL have port counter_V, input, 10, live vertical scan position.
REQ-009 SHALL have port pixel_en, input, 1, active-video flag aligned with the counters.
REQ-010 SHALL have port pixel_on, output, 1, sprite pixel lit.
REQ-011 SHALL have port pixel_id, output, 4, entity ID of the lit pixel; 4'hF when unlit.
REQ-012 SHALL have port pixel_valid, output, 1, pixel_en aligned to pixel_on/pixel_id.

Function
REQ-013 SHALL register counter_H and pixel_en once (h_d1, en_d1) to align them with entity_in.
REQ-014 SHALL derive the in-tile column without divide/modulo: sub counter 0..UPSCALE_FACTOR-1 and col counter 0..TILE_SIZE-1; sub wraps at UPSCALE_FACTOR-1 and then col increments mod TILE_SIZE.
REQ-015 SHALL implement FSM SYNC_WAIT/TRACK; reset state SYNC_WAIT.
REQ-016 In any state, h_d1 == 0 SHALL load sub=1, col=0, use column 0 for the current pixel, and enter/stay TRACK.
REQ-017 In TRACK, h_d1 >= ACTIVE_H SHALL return the FSM to SYNC_WAIT.
REQ-018 In SYNC_WAIT, the pixel SHALL be treated as transparent.
REQ-019 SHALL hold an internal 16 ID x 8 row x 8 bit sprite ROM; bit index = column, with column 0 leftmost.
REQ-020 ROM ID 4'h0 SHALL be the diagonal test pattern: row r has only bit r set.
REQ-021 ROM ID 4'h1 SHALL be all ones.
REQ-022 ROM ID 4'hF SHALL be all zeros.
REQ-023 Orientation SHALL map (row r, col c) to the ROM address: 00 -> (r,c); 01 -> (r,7-c); 10 -> (7-r,c); 11 -> (7-r,7-c).
REQ-024 ID field 4'hF SHALL force transparent regardless of row/orientation bits; words 9'h1FF and 9'h0FF are both empty.
REQ-025 Pipeline stage 1 SHALL register row, ID, orientation, col and the transparent flag.
REQ-026 Pipeline stage 2 SHALL register the ROM bit select into the outputs.
REQ-027 Latency SHALL be exactly 2 cycles from entity_in to pixel_on/pixel_id.
REQ-028 Latency SHALL be exactly 3 cycles from counter_H/pixel_en to pixel_valid.
REQ-029 pixel_on SHALL be 1 only if stage-1 is TRACK, not transparent, ROM bit = 1 and en_d1 = 1.
REQ-030 pixel_id SHALL equal the stage-1 ID when pixel_on = 1, else 4'hF.
REQ-031 counter_V SHALL NOT affect output; it is reserved for a row cross-check.
REQ-032 h_d1 == 0 and a sub wrap in the same cycle SHALL be resolved in favour of the resync.
REQ-033 No handshake or back-pressure; one output per clock, unconditionally.

Reset
REQ-034 Asserting reset SHALL immediately force pixel_on=0, pixel_id=4'hF, pixel_valid=0, all pipeline and alignment registers to the empty/transparent value, sub=0, col=0, FSM=SYNC_WAIT.
REQ-035 After reset deassertion mid-line, outputs SHALL stay transparent until the first h_d1 == 0.
REQ-036 From the first h_d1 == 0 after reset deassertion, rendering SHALL be correct 2 cycles later.

Verification
REQ-037 Sweep counter_H 0..639, pixel_en=1, entity_in={row 3,ID 0,orient 00} constant -> pixel_on=1 only for h_d1 in 15..19 mod 40, each 2 cycles later; pixel_id=0 then.
REQ-038 Same sweep, orient 01 -> lit h_d1 in 20..24 mod 40; orient 10 -> lit h_d1 in 20..24 mod 40 (row 3 maps to ROM row 4).
REQ-039 entity_in=9'h0FF, then 9'h1FF, with ID 1 otherwise everywhere -> pixel_on=0, pixel_id=4'hF on those cycles.
REQ-040 Assert reset at h_d1=200 for 3 cycles -> outputs 0/F immediately; stay transparent until 2 cycles after next h_d1==0; then ID 1 gives pixel_on=1.
REQ-041 pixel_en low for h 100..109 with ID 1 -> pixel_valid=0 and pixel_on=0 for exactly those pixels, 3 cycles later.
REQ-042 Jump counter_H from 300 to 0 mid-line -> col resyncs to 0 on the h_d1==0 cycle; ID 0 row 0 lights the next 5 pixels.
